kara_seq: RTL and testbench

- Sequencer that computes a full W×W → 2W product by time-sharing one external half-width multiplier (mux128-style start/done interface).
- Splits the operands into halves and issues the four partial products hi·hi, hi·lo, lo·hi and lo·lo one at a time.
- Accumulates each product, shifted to its weight, into a 2W-bit accumulator.
- Replaces the four-multiplier parallel arrangement in area-constrained builds.

---
 rtl/kara_pkg.sv | 22 ++
 rtl/adder_512bit.sv | 11 +
 rtl/kara_seq.sv | 113 +++++++++++
 tb/tb_kara_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/kara_pkg.sv
// Shared types and constants for the time-shared W x W -> 2W multiplier sequencer.
package kara_pkg;
  localparam int KARA_W = 256;
  localparam int KARA_H = KARA_W / 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

  // Partial-product index: 0=hi*hi, 1=hi*lo, 2=lo*hi, 3=lo*lo
  typedef logic [1:0] pp_idx_t;

  localparam int KARA_SHIFT [4] = '{KARA_W, KARA_H, KARA_H, 0};

  // Weight of partial product k for an arbitrary operand width w
  function automatic int kara_shift(pp_idx_t k, int w);
    case (k)
      2'd0:    return w;
      2'd1,
      2'd2:    return w / 2;
      default: return 0;
    endcase
  endfunction
endpackage

// File: rtl/adder_512bit.sv
// Plain unsigned ripple-style adder with carry-in; carry-out is the MSB of dout.
module adder_512bit #(
  parameter int WIDTH = 512
) (
  input  logic [WIDTH-1:0] din_one,
  input  logic [WIDTH-1:0] din_two,
  input  logic             cin,
  output logic [WIDTH:0]   dout
);
  assign dout = {1'b0, din_one} + {1'b0, din_two} + {{WIDTH{1'b0}}, cin};
endmodule

// File: rtl/kara_seq.sv
// Sequencer computing a 2W-bit product by issuing four half-width partial
// products, one at a time, to a shared external multiplier.
module kara_seq
  import kara_pkg::*;
#(
  parameter int W       = KARA_W,
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [2*W-1:0] z,
  output logic           mul_start,
  output logic [W/2-1:0] mul_a,
  output logic [W/2-1:0] mul_b,
  input  logic [W-1:0]   mul_p,
  input  logic           mul_done
);
  localparam int H   = W / 2;
  localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t         state, state_nx;
  pp_idx_t        k;
  logic [W-1:0]   xq, yq;
  logic [2*W-1:0] acc, pp_shift, acc_sum;
  logic [2*W:0]   sum;
  logic           carry_unused;
  logic [WDW-1:0] wdog;
  logic           tmo;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (k)
      2'd0: begin mul_a = xq[W-1:H]; mul_b = yq[W-1:H]; end
      2'd1: begin mul_a = xq[W-1:H]; mul_b = yq[H-1:0]; end
      2'd2: begin mul_a = xq[H-1:0]; mul_b = yq[W-1:H]; end
      default: begin mul_a = xq[H-1:0]; mul_b = yq[H-1:0]; end
    endcase
  end

  assign pp_shift = {{W{1'b0}}, mul_p} << kara_shift(k, W);

  adder_512bit #(.WIDTH(2*W)) u_add (
    .din_one (acc),
    .din_two (pp_shift),
    .cin     (1'b0),
    .dout    (sum)
  );

  // Final sum is always < 2^(2W), so the carry is structurally zero
  assign {carry_unused, acc_sum} = sum;

  assign tmo = (state == WAIT) && !mul_done && (wdog == WDW'(TIMEOUT - 1));

  always_comb begin
    state_nx  = state;
    busy      = (state != IDLE);
    mul_start = (state == ISSUE);
    done      = (state == FIN);
    case (state)
      IDLE:  if (start) state_nx = ISSUE;
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (mul_done)  state_nx = (k == 2'd3) ? FIN : ISSUE;
        else if (tmo)  state_nx = IDLE;
      end
      FIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= '0;
      acc   <= '0;
      z     <= '0;
      xq    <= '0;
      yq    <= '0;
      wdog  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      err   <= tmo;
      case (state)
        IDLE: if (start) begin
          xq  <= x;
          yq  <= y;
          acc <= '0;
          k   <= '0;
        end
        ISSUE: wdog <= '0;
        WAIT: begin
          if (mul_done) begin
            acc <= acc_sum;
            // z is loaded on entry to FIN so it is already valid while done is high
            if (k == 2'd3) z <= acc_sum;
            else           k <= k + 2'd1;
          end else if (!tmo) begin
            wdog <= wdog + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_kara_seq.sv
// Randomized self-checking bench for kara_seq with a behavioural multiplier stub.
module tb_kara_seq;
  localparam int W  = 256;
  localparam int H  = 128;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   x, y;
  logic           busy, done, err;
  logic [2*W-1:0] z;
  logic           mul_start;
  logic [H-1:0]   mul_a, mul_b;
  logic [W-1:0]   mul_p;
  logic           mul_done;

  kara_seq #(.W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y),
    .busy(busy), .done(done), .err(err), .z(z),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Multiplier stub: D cycles from mul_start to a one-cycle mul_done
  int           stub_d     = 1;
  bit           stub_never = 1'b0;
  int           force_cnt  = 0;
  int           cnt        = 0;
  int           starts_n   = 0;
  logic [W-1:0] la, lb;
  logic [H-1:0] pa[$], pb[$];

  initial begin
    mul_done = 1'b0;
    mul_p    = '0;
    forever begin
      @(posedge clk); #1;
      mul_done = 1'b0;
      if (force_cnt > 0) begin
        force_cnt--;
        mul_done = 1'b1;
        mul_p    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && !stub_never) begin
          mul_done = 1'b1;
          mul_p    = la * lb;
        end
      end
      if (mul_start) begin
        starts_n++;
        la = {{H{1'b0}}, mul_a};
        lb = {{H{1'b0}}, mul_b};
        pa.push_back(mul_a);
        pb.push_back(mul_b);
        cnt = stub_d;
      end
    end
  end

  function automatic logic [W-1:0] rnd256();
    logic [W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  logic [2*W-1:0] last_z = '0;

  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int d, input bit inj);
    int cyc, done_at, ndone, busy_n, lim;
    logic [2*W-1:0] exp, z_done;
    logic [H-1:0] ea[4], eb[4];
    stub_d = d;
    pa.delete(); pb.delete();
    starts_n = 0;
    exp = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    @(negedge clk);
    x = a; y = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; done_at = 0; ndone = 0; busy_n = 0; z_done = '0;
    lim = 4 * (d + 1) + 12;
    while (cyc <= lim) begin
      if (busy) busy_n++;
      if (done) begin
        ndone++;
        if (done_at == 0) begin done_at = cyc; z_done = z; end
      end
      if (inj && cyc == 4) begin
        start = 1'b1; x = rnd256(); y = rnd256();
      end else start = 1'b0;
      if (done_at != 0 && cyc >= done_at + 3) break;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({nm, ":done_cycle"}, 512'(done_at), 512'(4 * (d + 1) + 1));
    chk({nm, ":done_count"}, 512'(ndone), 512'd1);
    chk({nm, ":z_at_done"}, z_done, exp);
    chk({nm, ":z_hold"}, z, exp);
    chk({nm, ":busy_cycles"}, 512'(busy_n), 512'(4 * (d + 1) + 1));
    chk({nm, ":mul_starts"}, 512'(starts_n), 512'd4);
    ea = '{a[W-1:H], a[W-1:H], a[H-1:0], a[H-1:0]};
    eb = '{b[W-1:H], b[H-1:0], b[W-1:H], b[H-1:0]};
    for (int i = 0; i < 4 && i < pa.size(); i++) begin
      chk($sformatf("%s:pair%0d", nm, i), {pa[i], pb[i]}, {256'd0, ea[i], eb[i]});
    end
    last_z = exp;
  endtask

  initial begin
    int cyc, err_at, nerr, busy_at_err;
    rst_n = 1'b0; start = 1'b0; x = '0; y = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst:busy", 512'(busy), 512'd0);
    chk("rst:done", 512'(done), 512'd0);
    chk("rst:err", 512'(err), 512'd0);
    chk("rst:mul_start", 512'(mul_start), 512'd0);
    chk("rst:z", z, '0);
    chk("rst:mul_ab", {256'd0, mul_a, mul_b}, '0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_op("small", 256'd3, 256'd5, 1, 1'b0);
    run_op("cross", 256'd1 << 128, 256'd1 << 128, 2, 1'b0);
    chk("cross:value", z, 512'd1 << 256);
    run_op("ones", '1, '1, 3, 1'b0);
    chk("ones:value", z, ('1 << 257) + 512'd1);
    run_op("ignstart", rnd256(), rnd256(), 2, 1'b1);
    for (int i = 0; i < 6; i++)
      run_op($sformatf("rand%0d", i), rnd256(), rnd256(), $urandom_range(1, 5), 1'b0);
    run_op("small2", 256'd3, 256'd5, 1, 1'b0);

    // Multiplier never answers: watchdog must abort and keep z
    stub_never = 1'b1; starts_n = 0;
    @(negedge clk); x = rnd256(); y = rnd256(); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 1; err_at = 0; nerr = 0; busy_at_err = 1;
    while (cyc <= 30) begin
      if (err) begin
        nerr++;
        if (err_at == 0) begin err_at = cyc; busy_at_err = busy; end
      end
      @(posedge clk); #1; cyc++;
    end
    chk("tmo:err_cycle", 512'(err_at), 512'(TO + 2));
    chk("tmo:err_count", 512'(nerr), 512'd1);
    chk("tmo:idle", 512'(busy_at_err), 512'd0);
    chk("tmo:z_kept", z, last_z);
    chk("tmo:one_start", 512'(starts_n), 512'd1);
    stub_never = 1'b0;
    run_op("after_tmo", rnd256(), rnd256(), 1, 1'b0);

    // Asynchronous reset in the middle of an operation
    stub_d = 1;
    @(negedge clk); x = rnd256(); y = rnd256(); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("mrst:busy", 512'(busy), 512'd0);
    chk("mrst:mul_start", 512'(mul_start), 512'd0);
    chk("mrst:done", 512'(done), 512'd0);
    chk("mrst:z", z, '0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    force_cnt = 2;
    nerr = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (busy || done || err || (z != '0)) nerr++;
    end
    chk("mrst:ignore_late_done", 512'(nerr), 512'd0);
    last_z = '0;
    run_op("after_rst", rnd256(), rnd256(), 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
